// File: rtl/widthadapt_pkg.sv
// Shared helpers for the packet-aware 1-to-x width upsizer.
package widthadapt_pkg;

   // Map beat position k within a word to its output lane.
   function automatic int unsigned lane_of(input int unsigned k, input int unsigned x,
                                           input bit msb_first);
      return msb_first ? (x - 1 - k) : k;
   endfunction

endpackage

// File: rtl/widthadapt_1_to_x_pkt.sv
// Packs p_x narrow beats into one wide word, with early flush on i_last,
// a lane keep mask and a decoupled output register.
module widthadapt_1_to_x_pkt
   import widthadapt_pkg::*;
#(
   parameter int unsigned  p_iwidth    = 16,
   parameter int unsigned  p_x         = 8,
   parameter bit           p_msb_first = 1'b0,
   localparam int unsigned p_owidth    = p_iwidth * p_x,
   localparam int unsigned p_xw        = $clog2(p_x)
) (
   input  logic                               i_clk,
   input  logic                               i_rst_n,
   input  logic                               i_valid,
   input  logic [p_iwidth-1:0]                i_data,
   input  logic                               i_last,
   output logic                               o_ready,
   output logic                               o_valid,
   output logic [p_owidth-1:0]                o_data,
   output logic [p_x-1:0][p_iwidth-1:0]       o_data_array,
   output logic [p_x-1:0]                     o_keep,
   output logic                               o_last,
   input  logic                               i_ready
);

   logic [p_x-1:0][p_iwidth-1:0] acc_data_q, acc_data_d, merge_data;
   logic [p_x-1:0]               acc_keep_q, acc_keep_d, merge_keep;
   logic [p_xw-1:0]              acc_cnt_q, acc_cnt_d;
   logic                         pending_q, pending_d;
   logic                         pend_last_q, pend_last_d;
   logic [p_x-1:0][p_iwidth-1:0] out_data_q, out_data_d;
   logic [p_x-1:0]               out_keep_q, out_keep_d;
   logic                         out_last_q, out_last_d;
   logic                         out_valid_q, out_valid_d;

   logic [p_xw-1:0] lane;
   logic            in_xfer;
   logic            out_free;
   logic            completing;

   assign lane       = p_xw'(lane_of(int'(acc_cnt_q), p_x, p_msb_first));
   assign in_xfer    = i_valid & ~pending_q;
   assign out_free   = ~out_valid_q | i_ready;
   assign completing = (acc_cnt_q == p_xw'(p_x - 1)) | i_last;

   // Accumulator contents with the current beat written into its lane.
   always_comb begin
      merge_data       = acc_data_q;
      merge_keep       = acc_keep_q;
      merge_data[lane] = i_data;
      merge_keep[lane] = 1'b1;
   end

   // Next-state for accumulator, pending flag and output register.
   always_comb begin
      acc_data_d  = acc_data_q;
      acc_keep_d  = acc_keep_q;
      acc_cnt_d   = acc_cnt_q;
      pending_d   = pending_q;
      pend_last_d = pend_last_q;
      out_data_d  = out_data_q;
      out_keep_d  = out_keep_q;
      out_last_d  = out_last_q;
      out_valid_d = out_valid_q;

      // Drain; any load below overrides so back-to-back words have no bubble.
      if (out_valid_q && i_ready) begin
         out_valid_d = 1'b0;
      end

      if (pending_q && out_free) begin
         out_data_d  = acc_data_q;
         out_keep_d  = acc_keep_q;
         out_last_d  = pend_last_q;
         out_valid_d = 1'b1;
         acc_data_d  = '0;
         acc_keep_d  = '0;
         acc_cnt_d   = '0;
         pending_d   = 1'b0;
      end else if (in_xfer) begin
         if (completing && out_free) begin
            out_data_d  = merge_data;
            out_keep_d  = merge_keep;
            out_last_d  = i_last;
            out_valid_d = 1'b1;
            acc_data_d  = '0;
            acc_keep_d  = '0;
            acc_cnt_d   = '0;
         end else if (completing) begin
            // Output busy: park the finished word until the register frees up.
            acc_data_d  = merge_data;
            acc_keep_d  = merge_keep;
            pending_d   = 1'b1;
            pend_last_d = i_last;
         end else begin
            acc_data_d = merge_data;
            acc_keep_d = merge_keep;
            acc_cnt_d  = acc_cnt_q + p_xw'(1);
         end
      end
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         acc_data_q  <= '0;
         acc_keep_q  <= '0;
         acc_cnt_q   <= '0;
         pending_q   <= 1'b0;
         pend_last_q <= 1'b0;
         out_data_q  <= '0;
         out_keep_q  <= '0;
         out_last_q  <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         acc_data_q  <= acc_data_d;
         acc_keep_q  <= acc_keep_d;
         acc_cnt_q   <= acc_cnt_d;
         pending_q   <= pending_d;
         pend_last_q <= pend_last_d;
         out_data_q  <= out_data_d;
         out_keep_q  <= out_keep_d;
         out_last_q  <= out_last_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign o_ready      = ~pending_q;
   assign o_valid      = out_valid_q;
   assign o_data       = out_data_q;
   assign o_data_array = out_data_q;
   assign o_keep       = out_keep_q;
   assign o_last       = out_last_q;

endmodule

// File: tb/tb_widthadapt_1_to_x_pkt.sv
// Directed and randomised checks of the packet-aware 1-to-x upsizer (8-bit beats, x4).
module tb_widthadapt_1_to_x_pkt;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        i_valid;
   logic [7:0]  i_data;
   logic        i_last;
   logic        i_ready;

   logic            a_ready, a_valid, a_last;
   logic [31:0]     a_data;
   logic [3:0][7:0] a_arr;
   logic [3:0]      a_keep;
   logic            b_ready, b_valid, b_last;
   logic [31:0]     b_data;
   logic [3:0][7:0] b_arr;
   logic [3:0]      b_keep;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   widthadapt_1_to_x_pkt #(.p_iwidth(8), .p_x(4), .p_msb_first(1'b0)) u_lsb (
      .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .i_data(i_data), .i_last(i_last),
      .o_ready(a_ready), .o_valid(a_valid), .o_data(a_data), .o_data_array(a_arr),
      .o_keep(a_keep), .o_last(a_last), .i_ready(i_ready)
   );

   widthadapt_1_to_x_pkt #(.p_iwidth(8), .p_x(4), .p_msb_first(1'b1)) u_msb (
      .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .i_data(i_data), .i_last(i_last),
      .o_ready(b_ready), .o_valid(b_valid), .o_data(b_data), .o_data_array(b_arr),
      .o_keep(b_keep), .o_last(b_last), .i_ready(i_ready)
   );

   typedef struct {
      logic        v;
      logic [7:0]  d;
      logic        l;
      logic        r;
      logic        ev;
      logic [31:0] ed;
      logic [3:0]  ek;
      logic        el;
      logic        erdy;
   } vec_t;

   typedef struct {
      logic [31:0] data;
      logic [3:0]  keep;
      logic        last;
   } word_t;

   vec_t  tbl[21];
   word_t sb_q[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic v, input logic [7:0] d, input logic l, input logic r,
                               input logic ev, input logic [31:0] ed, input logic [3:0] ek,
                               input logic el, input logic erdy);
      vec_t t;
      t.v = v; t.d = d; t.l = l; t.r = r;
      t.ev = ev; t.ed = ed; t.ek = ek; t.el = el; t.erdy = erdy;
      return t;
   endfunction

   // One clock: drive on the falling edge, sample 1 ns after the rising edge.
   task automatic step(input logic v, input logic [7:0] d, input logic l, input logic r);
      @(negedge clk);
      i_valid = v; i_data = d; i_last = l; i_ready = r;
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [3:0][7:0] m_data;
      logic [3:0]      m_keep;
      int              m_cnt;
      int              beats;
      word_t           w;

      rst_n = 1'b0; i_valid = 1'b0; i_data = '0; i_last = 1'b0; i_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("reset o_valid", 32'(a_valid), 32'd0);
      chk("reset o_keep", 32'(a_keep), 32'd0);
      chk("reset o_last", 32'(a_last), 32'd0);
      chk("reset o_data", a_data, 32'd0);
      chk("reset o_ready", 32'(a_ready), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;

      //            v  d      l  r   ev ed             ek       el rdy
      tbl[0]  = mk(1, 8'h11, 0, 1,  0, 32'h0,         4'h0,    0, 1);
      tbl[1]  = mk(1, 8'h22, 0, 1,  0, 32'h0,         4'h0,    0, 1);
      tbl[2]  = mk(1, 8'h33, 0, 1,  0, 32'h0,         4'h0,    0, 1);
      tbl[3]  = mk(1, 8'h44, 0, 1,  1, 32'h44332211,  4'b1111, 0, 1);
      tbl[4]  = mk(1, 8'hA1, 0, 1,  0, 32'h0,         4'h0,    0, 1);
      tbl[5]  = mk(1, 8'hA2, 0, 1,  0, 32'h0,         4'h0,    0, 1);
      tbl[6]  = mk(1, 8'hA3, 1, 1,  1, 32'h00A3A2A1,  4'b0111, 1, 1);
      tbl[7]  = mk(1, 8'hB1, 1, 1,  1, 32'h000000B1,  4'b0001, 1, 1);
      tbl[8]  = mk(0, 8'h00, 0, 1,  0, 32'h0,         4'h0,    0, 1);
      tbl[9]  = mk(1, 8'h01, 0, 0,  0, 32'h0,         4'h0,    0, 1);
      tbl[10] = mk(1, 8'h02, 0, 0,  0, 32'h0,         4'h0,    0, 1);
      tbl[11] = mk(1, 8'h03, 0, 0,  0, 32'h0,         4'h0,    0, 1);
      tbl[12] = mk(1, 8'h04, 0, 0,  1, 32'h04030201,  4'b1111, 0, 1);
      tbl[13] = mk(1, 8'h05, 0, 0,  1, 32'h04030201,  4'b1111, 0, 1);
      tbl[14] = mk(1, 8'h06, 0, 0,  1, 32'h04030201,  4'b1111, 0, 1);
      tbl[15] = mk(1, 8'h07, 0, 0,  1, 32'h04030201,  4'b1111, 0, 1);
      tbl[16] = mk(1, 8'h08, 0, 0,  1, 32'h04030201,  4'b1111, 0, 0);
      tbl[17] = mk(1, 8'h99, 1, 1,  1, 32'h08070605,  4'b1111, 0, 1);
      tbl[18] = mk(0, 8'h00, 0, 1,  0, 32'h0,         4'h0,    0, 1);
      tbl[19] = mk(1, 8'hD1, 1, 1,  1, 32'h000000D1,  4'b0001, 1, 1);
      tbl[20] = mk(0, 8'h00, 0, 1,  0, 32'h0,         4'h0,    0, 1);

      for (int i = 0; i < 21; i++) begin
         step(tbl[i].v, tbl[i].d, tbl[i].l, tbl[i].r);
         chk($sformatf("vec%0d o_valid", i), 32'(a_valid), 32'(tbl[i].ev));
         chk($sformatf("vec%0d o_ready", i), 32'(a_ready), 32'(tbl[i].erdy));
         if (tbl[i].ev) begin
            chk($sformatf("vec%0d o_data", i), a_data, tbl[i].ed);
            chk($sformatf("vec%0d o_keep", i), 32'(a_keep), 32'(tbl[i].ek));
            chk($sformatf("vec%0d o_last", i), 32'(a_last), 32'(tbl[i].el));
         end
      end

      // Reset mid-word with a held output word and two partial beats.
      step(1, 8'hE1, 0, 0);
      step(1, 8'hE2, 0, 0);
      step(1, 8'hE3, 0, 0);
      step(1, 8'hE4, 0, 0);
      step(1, 8'hE5, 0, 0);
      step(1, 8'hE6, 0, 0);
      chk("pre-reset held word", 32'(a_valid), 32'd1);
      @(negedge clk);
      rst_n = 1'b0; i_valid = 1'b0; i_ready = 1'b0;
      @(posedge clk);
      #1;
      chk("mid reset o_valid", 32'(a_valid), 32'd0);
      chk("mid reset o_keep", 32'(a_keep), 32'd0);
      chk("mid reset o_ready", 32'(a_ready), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      step(1, 8'hC1, 0, 1);
      step(1, 8'hC2, 0, 1);
      step(1, 8'hC3, 0, 1);
      step(1, 8'hC4, 0, 1);
      chk("post reset o_valid", 32'(a_valid), 32'd1);
      chk("post reset o_data", a_data, 32'hC4C3C2C1);
      chk("post reset o_keep", 32'(a_keep), 32'hF);
      chk("post reset lane2", 32'(a_arr[2]), 32'hC3);
      step(0, 8'h00, 0, 1);

      // Lane order: msb-first instance against lsb-first instance.
      step(1, 8'h11, 0, 1);
      step(1, 8'h22, 0, 1);
      step(1, 8'h33, 0, 1);
      step(1, 8'h44, 0, 1);
      chk("msb full o_data", b_data, 32'h11223344);
      chk("msb lane3", 32'(b_arr[3]), 32'h11);
      chk("lsb full o_data", a_data, 32'h44332211);
      step(0, 8'h00, 0, 1);
      step(1, 8'h5A, 1, 1);
      chk("msb single o_data", b_data, 32'h5A000000);
      chk("msb single o_keep", 32'(b_keep), 32'b1000);
      chk("msb single o_last", 32'(b_last), 32'd1);
      chk("lsb single o_data", a_data, 32'h0000005A);
      chk("lsb single o_keep", 32'(a_keep), 32'b0001);
      step(0, 8'h00, 0, 1);

      // Randomised stream against a transaction-level scoreboard.
      m_data = '0; m_keep = '0; m_cnt = 0; beats = 0;
      for (int cyc = 0; cyc < 2000 && beats < 64; cyc++) begin
         @(negedge clk);
         i_valid = ($urandom_range(0, 3) != 0);
         i_data  = 8'($urandom);
         i_last  = (beats == 63) || ($urandom_range(0, 4) == 0);
         i_ready = (beats < 32) ? 1'b1 : 1'($urandom_range(0, 1));
         #1;
         if (beats < 32) chk("o_ready while sink ready", 32'(a_ready), 32'd1);
         if (a_valid && i_ready) begin
            if (sb_q.size() == 0) begin
               chk("unexpected output word", 32'd1, 32'd0);
            end else begin
               w = sb_q.pop_front();
               chk("stream o_data", a_data, w.data);
               chk("stream o_keep", 32'(a_keep), 32'(w.keep));
               chk("stream o_last", 32'(a_last), 32'(w.last));
            end
         end
         if (i_valid && a_ready) begin
            m_data[m_cnt] = i_data;
            m_keep[m_cnt] = 1'b1;
            beats++;
            if (m_cnt == 3 || i_last) begin
               w.data = m_data; w.keep = m_keep; w.last = i_last;
               sb_q.push_back(w);
               m_data = '0; m_keep = '0; m_cnt = 0;
            end else begin
               m_cnt++;
            end
         end
         @(posedge clk);
      end
      chk("stream beats accepted", 32'(beats), 32'd64);

      // Drain everything still in flight.
      for (int cyc = 0; cyc < 20; cyc++) begin
         @(negedge clk);
         i_valid = 1'b0; i_last = 1'b0; i_ready = 1'b1;
         #1;
         if (a_valid) begin
            if (sb_q.size() == 0) begin
               chk("unexpected drain word", 32'd1, 32'd0);
            end else begin
               w = sb_q.pop_front();
               chk("drain o_data", a_data, w.data);
               chk("drain o_keep", 32'(a_keep), 32'(w.keep));
               chk("drain o_last", 32'(a_last), 32'(w.last));
            end
         end
         @(posedge clk);
      end
      chk("scoreboard empty", 32'(sb_q.size()), 32'd0);
      #1;
      chk("final o_valid", 32'(a_valid), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/widthadapt_1_to_x_pkt.md
Name: widthadapt_1_to_x_pkt

Overview:
- Parametrised successor to the team's 1-to-x width upsizer. Packs p_x narrow input beats into one wide output word on a valid/ready stream.
- Adds the following over the 1-to-x upsizer:
  - packet-aware early flush on i_last, with o_keep lane mask and o_last;
  - selectable lane order;
  - a decoupled output register, so the block sustains one input beat per cycle under continuous sink readiness.
- Sits between narrow producers (sensor/pixel readers) and wide consumers (frame buffer writers, SDRAM bursts).

Parameters:
- p_iwidth, 16, input beat width in bits (>=1).
- p_x, 8, beats per output word; power of two, >=2.
- p_msb_first, 0, 0: beat k goes to lane k (lane 0 = o_data[p_iwidth-1:0]); 1: beat k goes to lane p_x-1-k.
- p_owidth (localparam), p_iwidth*p_x, output width.
- p_xw (localparam), $clog2(p_x), lane index width.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  synchronous active-low reset.
- i_valid  in  1  input beat valid.
- i_data  in  p_iwidth  input beat.
- i_last  in  1  final beat of packet; qualified by i_valid.
- o_ready  out  1  block accepts a beat this cycle.
- o_valid  out  1  output word valid.
- o_data  out  p_owidth  packed word.
- o_data_array  out  p_iwidth x [p_x]  same word as lanes; o_data[i*p_iwidth +: p_iwidth] == o_data_array[i].
- o_keep  out  p_x  lane i holds a real beat.
- o_last  out  1  word ends a packet.
- i_ready  in  1  sink accepts the output word.

Behaviour:
- Interface rule: one clock; reset is synchronous and active-low (i_clk, i_rst_n).
- Reset values (i_rst_n sampled 0 at edge): o_valid=0, o_keep=0, o_last=0, o_data=0, accumulator count=0, pending=0, accumulator data=0.
- Reset mid-word discards all partial and held data; no word is emitted for it.
- Transfer definitions:
  - input transfer = i_valid & o_ready;
  - output transfer = o_valid & i_ready.
- State is held in three registers:
  - accumulator: data, keep, count acc_cnt in 0..p_x-1;
  - pending flag: the accumulator holds a completed word;
  - output register: o_data, o_keep, o_last, o_valid.
- out_free = ~o_valid | i_ready.
- o_ready = ~pending. o_ready is registered-only; there is no combinational path from i_ready or i_valid.
- Non-completing beat: an input transfer with acc_cnt<p_x-1 and i_last=0 writes i_data into lane(acc_cnt), sets keep(lane), and increments acc_cnt.
- Completing beat: an input transfer with acc_cnt==p_x-1 or i_last=1.
  - If out_free: the output register loads accumulator contents merged with the current beat; o_keep = accumulated keep plus the current lane; o_last = i_last; o_valid=1. The accumulator clears (data 0, keep 0, cnt 0).
  - Else: the beat merges into the accumulator, pending=1, and the latched last flag = i_last.
- When pending and out_free: the output register loads the accumulator and latched last; the accumulator clears; pending=0. No input is accepted in this cycle, because o_ready was 0.
- When an output transfer occurs with no new word to load: o_valid=0 next cycle. o_data, o_keep and o_last hold their values but are don't-care.
- Unused lanes (keep=0) are driven 0.
- Latency: o_valid asserts the cycle after the completing beat when the output is free.
- Throughput: 1 beat/cycle while i_ready=1.
- i_last on beat 0: emits a single-lane word (keep has one bit set).
- i_last on beat p_x-1: identical to a normal full word, but o_last=1.
- i_valid=0 cycles: no state change except output drain.
- i_last without i_valid: ignored.
- Simultaneous output transfer and completing beat: the output register reloads in the same edge, so there is no bubble.

Decomposition:
- Package widthadapt_pkg holds:
  - function lane_of(k, p_x, msb_first) returning the lane index;
  - typedef struct {data, keep, last} for the output word, parametrised via the module's localparams where the tool allows;
  - otherwise, constants only.
- No sub-module. The output register is inline, since it is a single stage.

Test Plan:
- Lane packing, p_iwidth=8, p_x=4, i_ready=1. Beats 0x11,0x22,0x33,0x44 → one cycle after the 4th beat: o_data=0x44332211, o_keep=4'b1111, o_last=0. o_ready stays 1 throughout.
- Early flush: beats 0xA1,0xA2,0xA3 with i_last on 0xA3 → o_data=0x00A3A2A1, o_keep=4'b0111, o_last=1. The next beat 0xB1 starts at lane 0.
- Back-pressure: i_ready=0, 8 contiguous beats 0x01..0x08 → o_data=0x04030201 is held. After the 8th beat, pending=1 and o_ready=0. Raise i_ready → 0x04030201 pops, 0x08070605 appears on the next cycle, and o_ready returns to 1.
- Lane order, p_msb_first=1: beats 0x11,0x22,0x33,0x44 → o_data=0x11223344. A single beat 0x5A with i_last → o_data=0x5A000000, o_keep=4'b1000.
- Reset mid-word: 2 beats accepted, then i_rst_n=0 for 1 cycle → o_valid=0, o_keep=0. The next 4 beats 0xC1..0xC4 produce exactly 0xC4C3C2C1.
- Streaming: 64 random beats with random i_valid/i_ready and random i_last → scoreboard matches all words, keep and last. No beat is lost or duplicated. With i_ready held 1, o_ready is never 0.
